// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage in front of the core ALU.
// Takes an RV32 instruction plus rs1/rs2 values over valid/ready, maps the ISA
// encoding onto the ALU's {funct3_alu, Type_alu} op select, builds operand2
// (rs2, I-immediate, shamt or U-immediate) and presents the op through a
// two-entry (main + skid) registered output buffer. Illegal/unsupported words
// are consumed, reported on err_illegal/err_instr and never issued.
//
// Optional build macro: ALU_ISSUE_STATS_EN adds stat_issued/stat_illegal.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        input handshake (in_ready registered, = !skid_full)
//   in_instr                 RV32 instruction word
//   in_rs1_val, in_rs2_val   register operands
//   out_valid/out_ready      output handshake
//   operand1, operand2       ALU operands
//   funct3_alu, Type_alu     ALU op select / variant
//   out_rd                   destination register
//   err_illegal              illegal instruction flag (pulse or sticky)
//   err_instr                last illegal instruction word
//   stat_issued, stat_illegal  (ALU_ISSUE_STATS_EN only) wrapping counters
module alu_issue #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ILLEGAL_PULSE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [2:0]      funct3_alu,
    output logic            Type_alu,
    output logic [4:0]      out_rd,
    output logic            err_illegal,
    output logic [31:0]     err_instr
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [2:0]      f3;
        logic            typ;
        logic [4:0]      rd;
    } op_t;

    // Base ISA funct3 -> {funct3_alu, Type_alu}; SLTU/XOR/OR use variant 1.
    function automatic logic [3:0] base_map(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b000_0;
            3'b001:  m = 4'b001_0;
            3'b010:  m = 4'b010_0;
            3'b011:  m = 4'b010_1;
            3'b100:  m = 4'b100_1;
            3'b101:  m = 4'b101_0;
            3'b110:  m = 4'b110_1;
            default: m = 4'b111_0;
        endcase
        return m;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_imm_u;
    op_t             w_dec;
    logic            w_legal;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_illegal_acc;
    logic            w_skid_valid_nxt;
    logic            w_err_nxt;

    op_t             r_main;
    op_t             r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;
    logic            r_in_ready;
    logic            r_err_illegal;
    logic [31:0]     r_err_instr;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
    assign w_shamt  = XLEN'(in_instr[24:20]);
    assign w_imm_u  = XLEN'({in_instr[31:12], 12'b0});

    // Instruction decode: legality plus the ALU payload.
    always_comb begin
        w_legal   = 1'b0;
        w_dec     = '0;
        w_dec.op1 = in_rs1_val;
        w_dec.op2 = in_rs2_val;
        w_dec.rd  = in_instr[11:7];
        case (w_opcode)
            OPC_OP: begin
                case (w_f7)
                    F7_BASE: begin
                        w_legal               = 1'b1;
                        {w_dec.f3, w_dec.typ} = base_map(w_f3);
                    end
                    F7_ALT: begin
                        if (w_f3 == 3'b000) begin
                            w_legal               = 1'b1;
                            {w_dec.f3, w_dec.typ} = 4'b000_1;
                        end else if (w_f3 == 3'b101) begin
                            w_legal               = 1'b1;
                            {w_dec.f3, w_dec.typ} = 4'b001_1;
                        end
                    end
                    F7_MULDIV: begin
                        if (w_f3 == 3'b000) begin
                            w_legal               = 1'b1;
                            {w_dec.f3, w_dec.typ} = 4'b011_1;
                        end else if (w_f3 == 3'b100) begin
                            w_legal               = 1'b1;
                            {w_dec.f3, w_dec.typ} = 4'b011_0;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                w_dec.op2 = w_imm_i;
                if (w_f3 == 3'b001) begin
                    w_dec.op2 = w_shamt;
                    if (w_f7 == F7_BASE) begin
                        w_legal               = 1'b1;
                        {w_dec.f3, w_dec.typ} = 4'b001_0;
                    end
                end else if (w_f3 == 3'b101) begin
                    w_dec.op2 = w_shamt;
                    if (w_f7 == F7_BASE) begin
                        w_legal               = 1'b1;
                        {w_dec.f3, w_dec.typ} = 4'b101_0;
                    end else if (w_f7 == F7_ALT) begin
                        w_legal               = 1'b1;
                        {w_dec.f3, w_dec.typ} = 4'b001_1;
                    end
                end else begin
                    w_legal               = 1'b1;
                    {w_dec.f3, w_dec.typ} = base_map(w_f3);
                end
            end
            OPC_LUI: begin
                w_legal               = 1'b1;
                w_dec.op1             = '0;
                w_dec.op2             = w_imm_u;
                {w_dec.f3, w_dec.typ} = 4'b100_0;
            end
            default: ;
        endcase
    end

    // Handshake events; a push can only happen while the skid is empty.
    assign w_accept      = in_valid && r_in_ready;
    assign w_push        = w_accept && w_legal;
    assign w_illegal_acc = w_accept && !w_legal;
    assign w_pop         = r_main_valid && out_ready;

    always_comb begin
        w_skid_valid_nxt = 1'b0;
        if (r_skid_valid) begin
            w_skid_valid_nxt = !w_pop;
        end else begin
            w_skid_valid_nxt = w_push && r_main_valid && !w_pop;
        end
    end

    always_comb begin
        w_err_nxt = r_err_illegal;
        if (ILLEGAL_PULSE != 0) begin
            w_err_nxt = w_illegal_acc;
        end else if (w_illegal_acc) begin
            w_err_nxt = 1'b1;
        end else if (w_accept) begin
            w_err_nxt = 1'b0;
        end
    end

    // Main/skid buffer and error capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main        <= '0;
            r_skid        <= '0;
            r_main_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_in_ready    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_instr   <= '0;
        end else begin
            if (r_skid_valid) begin
                if (w_pop) begin
                    r_main <= r_skid;
                end
            end else if (w_push) begin
                if (!r_main_valid || w_pop) begin
                    r_main <= w_dec;
                end else begin
                    r_skid <= w_dec;
                end
                r_main_valid <= 1'b1;
            end else if (w_pop) begin
                r_main_valid <= 1'b0;
            end
            r_skid_valid  <= w_skid_valid_nxt;
            r_in_ready    <= !w_skid_valid_nxt;
            r_err_illegal <= w_err_nxt;
            if (w_illegal_acc) begin
                r_err_instr <= in_instr;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign operand1    = r_main.op1;
    assign operand2    = r_main.op2;
    assign funct3_alu  = r_main.f3;
    assign Type_alu    = r_main.typ;
    assign out_rd      = r_main.rd;
    assign err_illegal = r_err_illegal;
    assign err_instr   = r_err_instr;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_illegal;

    // Wrapping event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_issued  <= '0;
            r_stat_illegal <= '0;
        end else begin
            if (w_pop) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (w_illegal_acc) begin
                r_stat_illegal <= r_stat_illegal + 32'd1;
            end
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
